// File: rtl/ps2_pkg.sv
// Shared PS/2 receive constants, FSM state encoding and the odd-parity helper.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam int         PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    function automatic logic odd_parity_ok(input logic [7:0] dat, input logic par);
        return ^{dat, par};
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// 2-FF synchroniser plus FILTER_LEN-sample debounce for one slow line; level resets high.
// Latency: level/fall follow the raw line by 2 + FILTER_LEN cycles; no backpressure.
module ps2_sync_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          fall_q,  fall_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    // cnt_q counts consecutive synchronised samples that disagree with the held level.
    always_comb begin
        sync1_d = line_i;
        sync2_d = sync1_q;
        level_d = level_q;
        fall_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_d = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: filtered frames -> make/break events with F0/E0 qualifiers; optional err_count via PS2_RX_ERR_CNT_EN.
// Latency: key_valid/frame_err 1 clk after the stop-bit strobe; no backpressure (events are single-cycle pulses).
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_release,
    output logic       key_extended,
    output logic       frame_err,
    output logic       busy
`ifdef PS2_RX_ERR_CNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam int DATA_BITS = PS2_FRAME_BITS - 3;
    localparam int TW        = $clog2(TIMEOUT_CYC + 1);

    logic clk_lvl;
    logic clk_fall;
    logic strobe;

    ps2_sync_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filt (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_i  (ps2_clk),
        .level_o (clk_lvl),
        .fall_o  (clk_fall)
    );

    assign strobe = clk_fall & ~clk_lvl;

    ps2_state_e    state_q,    state_d;
    logic          dsync1_q,   dsync1_d;
    logic          dsync2_q,   dsync2_d;
    logic [2:0]    bit_idx_q,  bit_idx_d;
    logic [7:0]    shift_q,    shift_d;
    logic          par_q,      par_d;
    logic [TW-1:0] to_cnt_q,   to_cnt_d;
    logic          rel_flag_q, rel_flag_d;
    logic          ext_flag_q, ext_flag_d;
    logic          key_valid_q, key_valid_d;
    logic [7:0]    key_code_q,  key_code_d;
    logic          key_rel_q,   key_rel_d;
    logic          key_ext_q,   key_ext_d;
    logic          frame_err_q, frame_err_d;
    logic          timeout;
`ifdef PS2_RX_ERR_CNT_EN
    logic [7:0]    err_cnt_q,   err_cnt_d;
`endif

    assign timeout = (state_q != IDLE) && (to_cnt_q == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d     = state_q;
        dsync1_d    = ps2_data;
        dsync2_d    = dsync1_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        par_d       = par_q;
        rel_flag_d  = rel_flag_q;
        ext_flag_d  = ext_flag_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_rel_d   = key_rel_q;
        key_ext_d   = key_ext_q;
        frame_err_d = 1'b0;
        to_cnt_d    = '0;

        // A strobe landing in the timeout cycle is ignored.
        if (timeout) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
            rel_flag_d  = 1'b0;
            ext_flag_d  = 1'b0;
        end else if (strobe) begin
            unique case (state_q)
                IDLE: begin
                    if (!dsync2_q) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                DATA: begin
                    shift_d   = {dsync2_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = dsync2_q;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!(odd_parity_ok(shift_q, par_q) && dsync2_q)) begin
                        frame_err_d = 1'b1;
                        rel_flag_d  = 1'b0;
                        ext_flag_d  = 1'b0;
                    end else if (shift_q == PS2_BREAK) begin
                        rel_flag_d = 1'b1;
                    end else if (shift_q == PS2_EXT) begin
                        ext_flag_d = 1'b1;
                    end else begin
                        key_valid_d = 1'b1;
                        key_code_d  = shift_q;
                        key_rel_d   = rel_flag_q;
                        key_ext_d   = ext_flag_q;
                        rel_flag_d  = 1'b0;
                        ext_flag_d  = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // The strobe cycle counts as cycle 0 of the idle window.
        if (state_d != IDLE) begin
            to_cnt_d = strobe ? TW'(1) : to_cnt_q + 1'b1;
        end
    end

`ifdef PS2_RX_ERR_CNT_EN
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (frame_err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dsync1_q    <= 1'b1;
            dsync2_q    <= 1'b1;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            to_cnt_q    <= '0;
            rel_flag_q  <= 1'b0;
            ext_flag_q  <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            key_rel_q   <= 1'b0;
            key_ext_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef PS2_RX_ERR_CNT_EN
            err_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            dsync1_q    <= dsync1_d;
            dsync2_q    <= dsync2_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            to_cnt_q    <= to_cnt_d;
            rel_flag_q  <= rel_flag_d;
            ext_flag_q  <= ext_flag_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_rel_q   <= key_rel_d;
            key_ext_q   <= key_ext_d;
            frame_err_q <= frame_err_d;
`ifdef PS2_RX_ERR_CNT_EN
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

    assign key_valid    = key_valid_q;
    assign key_code     = key_code_q;
    assign key_release  = key_rel_q;
    assign key_extended = key_ext_q;
    assign frame_err    = frame_err_q;
    assign busy         = (state_q != IDLE);
`ifdef PS2_RX_ERR_CNT_EN
    assign err_count    = err_cnt_q;
`endif

endmodule
